traffic_sensor_conditioner: RTL and testbench
=============================================

Name: traffic_sensor_conditioner

Overview:
- Upstream stage of the 5-direction traffic light controller. Takes raw loop-detector inputs for the five approaches (E straight, W straight, E left, W left, NS) and drives the controller's sensor inputs.
- Per channel it provides: 2-flop synchronisation, a debounce filter, a pending-request latch, and stuck-detector masking.
- Pending latch: a car that arrives and then leaves the loop keeps its request until its light turns green.
- Stuck masking: a detector that reads "occupied" forever cannot hold other approaches off.
- Consumes the controller's light outputs, which it uses to clear served requests.

Parameters:
- DEBOUNCE, 4: consecutive synchronised cycles an input must differ from its filtered value before the filtered value flips; legal range 1..255.
- STUCK_LIMIT, 255: consecutive cycles of filtered-high after which a channel is declared stuck; legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- e_str_raw  input  1  raw E straight detector, asynchronous
- w_str_raw  input  1  raw W straight detector, asynchronous
- e_left_raw  input  1  raw E left detector, asynchronous
- w_left_raw  input  1  raw W left detector, asynchronous
- ns_raw  input  1  raw NS detector, asynchronous
- e_str_light  input  2  light_package colors (red/yellow/green) from controller
- w_str_light  input  2  same, W straight
- e_left_light  input  2  same, E left
- w_left_light  input  2  same, W left
- ns_light  input  2  same, NS
- e_str_sensor  output  1  conditioned request to controller
- w_str_sensor  output  1  conditioned request
- e_left_sensor  output  1  conditioned request
- w_left_sensor  output  1  conditioned request
- ns_sensor  output  1  conditioned request
- sensor_fault  output  5  stuck flags; bit order [4]=e_str, [3]=w_str, [2]=e_left, [1]=w_left, [0]=ns

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - reset_n low asynchronously clears all state: sync flops, filtered, debounce counters, pending, stuck counters, stuck flags.
  - While reset is asserted, all *_sensor outputs are 0 and sensor_fault is 5'b0.
  - Reset release mid-activity restarts filtering from 0; there is no memory of earlier requests.
- Five identical, independent channels, each with per-channel state: sync1, sync2, filtered, dcnt (8-bit), pending, scnt (16-bit), stuck.
- Synchroniser: sync1 <= raw; sync2 <= sync1.
- Debounce (dcnt):
  - If sync2 == filtered: dcnt <= 0.
  - Else if dcnt == DEBOUNCE-1: filtered <= ~filtered and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - A mismatch run shorter than DEBOUNCE cycles leaves filtered unchanged, and any return to equality restarts the count.
  - Latency: raw first sampled high at edge k gives filtered = 1 after edge k+1+DEBOUNCE. The same latency applies to the falling edge.
- Pending latch:
  - Set when filtered rises 0->1 and the channel's light != green.
  - Cleared on any cycle the light == green; clear wins over a simultaneous set.
  - Yellow and red do not clear it.
- Stuck detection:
  - While filtered == 1: scnt increments, saturating at STUCK_LIMIT. When scnt reaches STUCK_LIMIT, stuck <= 1.
  - filtered == 0 clears scnt and stuck on the next edge.
  - The light state does not affect scnt.
- Output (combinational from registers only, no raw-input path):
  - sensor = (filtered & ~stuck) | pending.
  - sensor_fault[i] = stuck of channel i.
- A stuck channel therefore requests service once, via the pending set on its original rise, and is then ignored until its detector reads clear.
- Unknown or illegal light encodings are treated as not-green.
- Channels never interact; simultaneous events on different channels are processed independently in the same cycle.

Test Plan:
(DEBOUNCE=4, STUCK_LIMIT=16, lights red unless stated)
- Reset: hold reset_n=0 with all raw=1 -> all sensors 0, sensor_fault=0. Release: e_str_sensor rises exactly 6 edges after the first post-reset sampling edge.
- Glitch reject: ns_raw high for 3 cycles, then low -> ns_sensor stays 0; dcnt returns to 0. A 4-cycle pulse -> filtered rises and pending latches, so ns_sensor = 1 and stays 1 after raw drops.
- Pending clear: w_left_raw pulse of 6 cycles latches pending. Then drive w_left_light=yellow for 5 cycles -> sensor stays 1. Then green for 1 cycle -> w_left_sensor = 0 the next cycle (raw low).
- Arrival during green: e_left_light=green, e_left_raw rises -> sensor follows filtered (1 while raw is held), pending never set. Raw low -> sensor 0 after 6 edges.
- Stuck: w_str_raw held at 1 with light red -> sensor_fault[3]=1 after 16 filtered-high cycles and sensor still 1 (pending). Light green for 1 cycle -> w_str_sensor = 0 despite raw=1. Raw low for 6+ cycles -> fault clears.
- Async reset mid-stuck: pulse reset_n low between edges -> sensor_fault and all sensors drop to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// Loop-detector conditioning for the five-approach traffic light controller.
// Each approach gets a 2-flop synchroniser, a debounce filter, a pending
// request latch that holds until the approach is served (green), and a
// stuck-detector mask so a permanently occupied loop cannot starve others.

// ---------------------------------------------------------------------------
// One conditioning channel. All five channels are identical and independent.
// ---------------------------------------------------------------------------
module traffic_sensor_channel #(
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw,
  input  logic [1:0] light,
  output logic       sensor,
  output logic       stuck
);

  // Controller light colour encoding; 2'b11 is illegal and treated as not-green.
  localparam logic [1:0] LIGHT_GREEN = 2'b10;

  localparam logic [7:0]  DCNT_LAST = 8'(DEBOUNCE - 1);
  localparam logic [15:0] SCNT_MAX  = 16'(STUCK_LIMIT);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        filtered_reg, filtered_next;
  logic [7:0]  dcnt_reg, dcnt_next;
  logic        pending_reg, pending_next;
  logic [15:0] scnt_reg, scnt_next;
  logic        stuck_reg, stuck_next;

  logic        light_green;
  logic        filtered_rise;

  assign light_green = (light == LIGHT_GREEN);

  // Two-flop synchroniser for the asynchronous loop detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: the filtered value flips only after DEBOUNCE consecutive
  // disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    filtered_next = filtered_reg;
    dcnt_next     = dcnt_reg;
    if (sync2_reg == filtered_reg) begin
      dcnt_next = 8'd0;
    end else if (dcnt_reg == DCNT_LAST) begin
      filtered_next = ~filtered_reg;
      dcnt_next     = 8'd0;
    end else begin
      dcnt_next = dcnt_reg + 8'd1;
    end
  end

  // A rising filtered edge is taken from the flip itself so the request is
  // latched on the same edge that filtered goes high.
  assign filtered_rise = ~filtered_reg & filtered_next;

  // Pending latch: set on arrival while not green, cleared whenever green
  // (clear has priority over a simultaneous set).
  always_comb begin
    pending_next = pending_reg;
    if (light_green) begin
      pending_next = 1'b0;
    end else if (filtered_rise) begin
      pending_next = 1'b1;
    end
  end

  // Stuck detection: count filtered-high cycles, saturating; the flag is
  // raised on the edge where the count reaches the limit and dropped as
  // soon as the detector reads clear.
  always_comb begin
    scnt_next  = scnt_reg;
    stuck_next = stuck_reg;
    if (filtered_reg) begin
      if (scnt_reg != SCNT_MAX) begin
        scnt_next = scnt_reg + 16'd1;
      end
      if (scnt_next == SCNT_MAX) begin
        stuck_next = 1'b1;
      end
    end else begin
      scnt_next  = 16'd0;
      stuck_next = 1'b0;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered_reg <= 1'b0;
      dcnt_reg     <= 8'd0;
      pending_reg  <= 1'b0;
      scnt_reg     <= 16'd0;
      stuck_reg    <= 1'b0;
    end else begin
      filtered_reg <= filtered_next;
      dcnt_reg     <= dcnt_next;
      pending_reg  <= pending_next;
      scnt_reg     <= scnt_next;
      stuck_reg    <= stuck_next;
    end
  end

  // Outputs come from registers only; a stuck detector is masked but an
  // outstanding pending request still reaches the controller.
  assign sensor = (filtered_reg & ~stuck_reg) | pending_reg;
  assign stuck  = stuck_reg;

endmodule

// ---------------------------------------------------------------------------
// Top level: five channels, bit order [4]=e_str .. [0]=ns.
// ---------------------------------------------------------------------------
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       e_str_raw,
  input  logic       w_str_raw,
  input  logic       e_left_raw,
  input  logic       w_left_raw,
  input  logic       ns_raw,
  input  logic [1:0] e_str_light,
  input  logic [1:0] w_str_light,
  input  logic [1:0] e_left_light,
  input  logic [1:0] w_left_light,
  input  logic [1:0] ns_light,
  output logic       e_str_sensor,
  output logic       w_str_sensor,
  output logic       e_left_sensor,
  output logic       w_left_sensor,
  output logic       ns_sensor,
  output logic [4:0] sensor_fault
);

  logic [4:0] raw_vec;
  logic [1:0] light_vec [5];
  logic [4:0] sensor_vec;
  logic [4:0] stuck_vec;

  assign raw_vec = {e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw};

  assign light_vec[4] = e_str_light;
  assign light_vec[3] = w_str_light;
  assign light_vec[2] = e_left_light;
  assign light_vec[1] = w_left_light;
  assign light_vec[0] = ns_light;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chan
      traffic_sensor_channel #(
        .DEBOUNCE    (DEBOUNCE),
        .STUCK_LIMIT (STUCK_LIMIT)
      ) u_chan (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (raw_vec[gi]),
        .light   (light_vec[gi]),
        .sensor  (sensor_vec[gi]),
        .stuck   (stuck_vec[gi])
      );
    end
  endgenerate

  assign e_str_sensor  = sensor_vec[4];
  assign w_str_sensor  = sensor_vec[3];
  assign e_left_sensor = sensor_vec[2];
  assign w_left_sensor = sensor_vec[1];
  assign ns_sensor     = sensor_vec[0];
  assign sensor_fault  = stuck_vec;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (DEBOUNCE=4, STUCK_LIMIT=16).
module tb_traffic_sensor_conditioner;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw;
  logic [1:0] e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
  logic       e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [4:0] sensor_fault;
  logic [4:0] sens;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  assign sens = {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor};

  traffic_sensor_conditioner #(
    .DEBOUNCE    (4),
    .STUCK_LIMIT (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .e_str_raw     (e_str_raw),
    .w_str_raw     (w_str_raw),
    .e_left_raw    (e_left_raw),
    .w_left_raw    (w_left_raw),
    .ns_raw        (ns_raw),
    .e_str_light   (e_str_light),
    .w_str_light   (w_str_light),
    .e_left_light  (e_left_light),
    .w_left_light  (w_left_light),
    .ns_light      (ns_light),
    .e_str_sensor  (e_str_sensor),
    .w_str_sensor  (w_str_sensor),
    .e_left_sensor (e_left_sensor),
    .w_left_sensor (w_left_sensor),
    .ns_sensor     (ns_sensor),
    .sensor_fault  (sensor_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    {e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw} = 5'b11111;
    e_str_light  = RED;
    w_str_light  = RED;
    e_left_light = RED;
    w_left_light = RED;
    ns_light     = RED;

    // Reset held with all detectors occupied.
    tick(3);
    check("reset_sensors", 32'(sens), 32'h0);
    check("reset_fault", 32'(sensor_fault), 32'h0);

    // Release: next edge is the first sampling edge; filtered after edge 6.
    reset_n = 1'b1;
    tick(5);
    check("release_edge5", 32'(sens), 32'h0);
    tick(1);
    check("release_edge6", 32'(sens), 32'h1F);

    // Async reset clears everything without a clock edge.
    {e_str_raw, w_str_raw, e_left_raw, w_left_raw, ns_raw} = 5'b00000;
    reset_n = 1'b0;
    #1;
    check("async_clear_sensors", 32'(sens), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_idle", 32'(sens), 32'h0);

    // Glitch reject: 3-cycle pulse on ns.
    ns_raw = 1'b1;
    tick(3);
    ns_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("glitch3_ns_%0d", i), 32'(ns_sensor), 32'h0);
    end

    // 4-cycle pulse is accepted and latched as pending.
    ns_raw = 1'b1;
    tick(4);
    ns_raw = 1'b0;
    tick(1);
    check("pulse4_ns_before", 32'(ns_sensor), 32'h0);
    tick(1);
    check("pulse4_ns_rise", 32'(ns_sensor), 32'h1);
    tick(10);
    check("pulse4_ns_pending", 32'(ns_sensor), 32'h1);
    ns_light = GREEN;
    tick(1);
    check("ns_green_clear", 32'(ns_sensor), 32'h0);
    ns_light = RED;
    tick(1);
    check("ns_after_clear", 32'(ns_sensor), 32'h0);

    // Pending clear only on green, not yellow.
    w_left_raw = 1'b1;
    tick(6);
    w_left_raw = 1'b0;
    tick(12);
    check("wl_pending_held", 32'(w_left_sensor), 32'h1);
    w_left_light = YELLOW;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("wl_yellow_%0d", i), 32'(w_left_sensor), 32'h1);
    end
    w_left_light = GREEN;
    tick(1);
    check("wl_green_clear", 32'(w_left_sensor), 32'h0);
    w_left_light = RED;
    tick(1);
    check("wl_after_clear", 32'(w_left_sensor), 32'h0);

    // Arrival while green: sensor follows filtered, no pending.
    e_left_light = GREEN;
    e_left_raw   = 1'b1;
    tick(5);
    check("el_green_edge5", 32'(e_left_sensor), 32'h0);
    tick(1);
    check("el_green_edge6", 32'(e_left_sensor), 32'h1);
    tick(5);
    check("el_green_held", 32'(e_left_sensor), 32'h1);
    e_left_raw = 1'b0;
    tick(5);
    check("el_fall_edge5", 32'(e_left_sensor), 32'h1);
    tick(1);
    check("el_fall_edge6", 32'(e_left_sensor), 32'h0);
    e_left_light = RED;
    tick(3);
    check("el_no_pending", 32'(e_left_sensor), 32'h0);

    // Stuck detector on w_str.
    w_str_raw = 1'b1;
    tick(6);
    check("ws_filtered_rise", 32'(w_str_sensor), 32'h1);
    tick(15);
    check("ws_not_yet_stuck", 32'(sensor_fault), 32'h00);
    tick(1);
    check("ws_stuck", 32'(sensor_fault), 32'h08);
    check("ws_stuck_pending", 32'(w_str_sensor), 32'h1);
    w_str_light = GREEN;
    tick(1);
    check("ws_green_masked", 32'(w_str_sensor), 32'h0);
    w_str_light = RED;
    tick(1);
    check("ws_still_masked", 32'(w_str_sensor), 32'h0);
    check("ws_fault_held", 32'(sensor_fault), 32'h08);
    w_str_raw = 1'b0;
    tick(6);
    check("ws_fault_edge6", 32'(sensor_fault), 32'h08);
    tick(1);
    check("ws_fault_cleared", 32'(sensor_fault), 32'h00);
    check("ws_sensor_idle", 32'(w_str_sensor), 32'h0);

    // Async reset while stuck.
    w_str_raw = 1'b1;
    tick(25);
    check("ws_restuck", 32'(sensor_fault), 32'h08);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_stuck_fault", 32'(sensor_fault), 32'h00);
    check("async_stuck_sensors", 32'(sens), 32'h0);
    w_str_raw = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
